// File: rtl/aes_decrypt_round_ctrl_if.sv
// Request/response and round-key bus of the AES inverse-cipher sequencer.
// slave = sequencer side; master = wrapper plus key store side.
interface aes_decrypt_round_ctrl_if #(
  parameter int KIDX_W = 4
);
  logic              start;
  logic              ready;
  logic [0:127]      in_block;
  logic [KIDX_W-1:0] rk_idx;
  logic [0:127]      rk_data;
  logic              out_valid;
  logic              out_ready;
  logic [0:127]      out_block;
  logic              busy;

  modport slave (
    input  start, in_block, rk_data, out_ready,
    output ready, rk_idx, out_valid, out_block, busy
  );

  modport master (
    output start, in_block, rk_data, out_ready,
    input  ready, rk_idx, out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_decrypt_round_ctrl.sv
// Iterative AES inverse cipher: one shared inverse round per clock, keys fetched by index.
// Optional macro AES_DEC_ABORT_EN adds an abort input that returns the FSM to IDLE.
module aes_decrypt_round_ctrl #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic clk,
  input  logic reset_n,
`ifdef AES_DEC_ABORT_EN
  input  logic abort,
`endif
  aes_decrypt_round_ctrl_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_decrypt_round_ctrl: NR must be 10, 12 or 14");
  end
  if ((2 ** KIDX_W) <= NR) begin : g_bad_kidx
    $error("aes_decrypt_round_ctrl: KIDX_W too narrow for NR");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RND, S_DONE} state_e;

  localparam logic [KIDX_W-1:0] LAST_KEY = KIDX_W'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine map followed by the field inverse computed as a^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a, p, r;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + 4 - r) % 4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[32*c + 8  +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // InvMixColumns is deferred to the start of the next round, so the first round skips it.
  function automatic logic [0:127] inv_round(input logic [0:127] s, input logic [0:127] k,
                                             input logic skip_mix);
    logic [0:127] u;
    u = inv_shift_rows(skip_mix ? s : inv_mix_columns(s));
    for (int i = 0; i < 16; i++) u[8*i +: 8] = inv_sbox(u[8*i +: 8]);
    return u ^ k;
  endfunction

  state_e            fsm_q, fsm_d;
  logic [0:127]      st_q, st_d;
  logic [0:127]      out_block_q, out_block_d;
  logic [KIDX_W-1:0] rk_idx_q, rk_idx_d;
  logic [KIDX_W-1:0] rnd_q, rnd_d;
  logic              first_q, first_d;
  logic              abort_act;
  logic [0:127]      round_out;

`ifdef AES_DEC_ABORT_EN
  assign abort_act = abort && (fsm_q != S_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign round_out = inv_round(st_q, bus.rk_data, first_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsm_q <= S_IDLE;
    else          fsm_q <= fsm_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    fsm_d = fsm_q;
    if (abort_act) begin
      fsm_d = S_IDLE;
    end else begin
      case (fsm_q)
        S_IDLE:  if (bus.start) fsm_d = S_LOAD;
        S_LOAD:  fsm_d = S_RND;
        S_RND:   if (rnd_q == '0) fsm_d = S_DONE;
        S_DONE:  if (bus.out_ready) fsm_d = S_IDLE;
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ready     = (fsm_q == S_IDLE);
    bus.busy      = (fsm_q == S_LOAD) || (fsm_q == S_RND);
    bus.out_valid = (fsm_q == S_DONE);
  end

  assign bus.rk_idx    = rk_idx_q;
  assign bus.out_block = out_block_q;

  always_comb begin
    st_d        = st_q;
    out_block_d = out_block_q;
    rk_idx_d    = rk_idx_q;
    rnd_d       = rnd_q;
    first_d     = first_q;
    if (abort_act) begin
      rk_idx_d = '0;
    end else begin
      case (fsm_q)
        S_IDLE: if (bus.start) begin
          st_d     = bus.in_block;
          rk_idx_d = LAST_KEY;
        end
        S_LOAD: begin
          st_d     = st_q ^ bus.rk_data;
          rk_idx_d = LAST_KEY - 1'b1;
          rnd_d    = LAST_KEY - 1'b1;
          first_d  = 1'b1;
        end
        S_RND: begin
          st_d    = round_out;
          first_d = 1'b0;
          if (rnd_q == '0) begin
            out_block_d = round_out;
          end else begin
            rnd_d    = rnd_q - 1'b1;
            rk_idx_d = rk_idx_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= '0;
      out_block_q <= '0;
      rk_idx_q    <= '0;
      rnd_q       <= '0;
      first_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      out_block_q <= out_block_d;
      rk_idx_q    <= rk_idx_d;
      rnd_q       <= rnd_d;
      first_q     <= first_d;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_round_ctrl.sv
// Self-checking bench: NR=10 and NR=14 sequencers against FIPS-197 vectors and a
// byte-level inverse-cipher model with its own key expansion and S-box tables.
module tb_aes_decrypt_round_ctrl;
  typedef logic [0:127] blk_t;

  typedef struct {
    int           d;
    logic [255:0] key;
    blk_t         ct;
    blk_t         pt;
    int           lat;
    int           stall;
    string        name;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic       start_s     [2];
  blk_t       in_s        [2];
  logic       out_ready_s [2];
`ifdef AES_DEC_ABORT_EN
  logic       abort_s     [2];
`endif
  logic [1:0] rdy_w, bsy_w, ov_w;
  logic [3:0] rkidx_w     [2];
  blk_t       ob_w        [2];

  blk_t       ks          [2][16];
  logic [7:0] sbox_t      [256];
  logic [7:0] inv_sbox_t  [256];

  aes_decrypt_round_ctrl_if #(.KIDX_W(4)) if_a ();
  aes_decrypt_round_ctrl_if #(.KIDX_W(4)) if_b ();

  assign if_a.start     = start_s[0];
  assign if_a.in_block  = in_s[0];
  assign if_a.out_ready = out_ready_s[0];
  assign if_a.rk_data   = ks[0][if_a.rk_idx];
  assign if_b.start     = start_s[1];
  assign if_b.in_block  = in_s[1];
  assign if_b.out_ready = out_ready_s[1];
  assign if_b.rk_data   = ks[1][if_b.rk_idx];

  assign rdy_w      = {if_b.ready, if_a.ready};
  assign bsy_w      = {if_b.busy, if_a.busy};
  assign ov_w       = {if_b.out_valid, if_a.out_valid};
  assign rkidx_w[0] = if_a.rk_idx;
  assign rkidx_w[1] = if_b.rk_idx;
  assign ob_w[0]    = if_a.out_block;
  assign ob_w[1]    = if_b.out_block;

  aes_decrypt_round_ctrl #(.NR(10), .KIDX_W(4)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef AES_DEC_ABORT_EN
    .abort   (abort_s[0]),
`endif
    .bus     (if_a)
  );

  aes_decrypt_round_ctrl #(.NR(14), .KIDX_W(4)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef AES_DEC_ABORT_EN
    .abort   (abort_s[1]),
`endif
    .bus     (if_b)
  );

  function automatic int nr_of(input int d);
    return (d == 0) ? 10 : 14;
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Forward S-box from a brute-force field inverse; the inverse table by lookup reversal.
  function automatic void build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_t[a]     = s;
      inv_sbox_t[s] = 8'(a);
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic void expand_key(input int d, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nk, nw;
    nk = nr_of(d) - 6;
    nw = 4 * (nr_of(d) + 1);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      ks[d][r] = (r <= nr_of(d)) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endfunction

  function automatic logic [7:0] imc_coef(input int i);
    case (i)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // Textbook inverse cipher on a byte array (column-major, byte index = row + 4*col).
  function automatic blk_t model_dec(input int d, input blk_t ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] col [4];
    logic [7:0] acc;
    blk_t o;
    int nr;
    nr = nr_of(d);
    for (int j = 0; j < 16; j++) s[j] = ct[8*j +: 8] ^ ks[d][nr][8*j +: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          t[row + 4*c] = s[row + 4*((c - row + 4) % 4)];
      for (int j = 0; j < 16; j++) s[j] = inv_sbox_t[t[j]] ^ ks[d][r][8*j +: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) col[i] = s[i + 4*c];
          for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc ^ mul(imc_coef((j - i + 4) % 4), col[j]);
            s[i + 4*c] = acc;
          end
        end
      end
    end
    for (int j = 0; j < 16; j++) o[8*j +: 8] = s[j];
    return o;
  endfunction

  function automatic blk_t rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int d, input string name);
    check({name, " ready"},     128'(rdy_w[d]),   128'd1);
    check({name, " busy"},      128'(bsy_w[d]),   128'd0);
    check({name, " out_valid"}, 128'(ov_w[d]),    128'd0);
    check({name, " rk_idx"},    128'(rkidx_w[d]), 128'd0);
    check({name, " out_block"}, ob_w[d],          128'd0);
  endtask

  task automatic do_accept(input int d, input blk_t ct);
    int n;
    n = 0;
    while (!rdy_w[d] && n < 50) begin
      tick();
      n++;
    end
    check("accept ready", 128'(rdy_w[d]), 128'd1);
    start_s[d] = 1'b1;
    in_s[d]    = ct;
    tick();
    start_s[d] = 1'b0;
    in_s[d]    = rand_blk();
  endtask

  // Follows one accepted block to completion; called right after the accepting edge.
  task automatic track(input int d, input blk_t exp_pt, input int exp_lat, input int stall,
                       input string name);
    int nr, k;
    nr = nr_of(d);
    k  = 0;
    out_ready_s[d] = (stall == 0);
    while (!ov_w[d] && k <= nr + 20) begin
      check($sformatf("%s rk_idx[%0d]", name, k), 128'(rkidx_w[d]), 128'((k <= nr) ? nr - k : 0));
      check($sformatf("%s ready/busy[%0d]", name, k), 128'({rdy_w[d], bsy_w[d]}), 128'(2'b01));
      start_s[d] = 1'($urandom_range(0, 1));
      in_s[d]    = rand_blk();
      tick();
      k++;
    end
    start_s[d] = 1'b0;
    check({name, " latency"}, 128'(k), 128'(exp_lat));
    check({name, " done rk_idx"}, 128'(rkidx_w[d]), 128'd0);
    check({name, " done rdy/busy/ov"}, 128'({rdy_w[d], bsy_w[d], ov_w[d]}), 128'(3'b001));
    check({name, " out_block"}, ob_w[d], exp_pt);
    for (int s = 0; s < stall; s++) begin
      start_s[d] = 1'($urandom_range(0, 1));
      in_s[d]    = rand_blk();
      tick();
      check($sformatf("%s stall rdy/busy/ov[%0d]", name, s),
            128'({rdy_w[d], bsy_w[d], ov_w[d]}), 128'(3'b001));
      check($sformatf("%s stall out_block[%0d]", name, s), ob_w[d], exp_pt);
    end
    start_s[d]     = 1'b0;
    out_ready_s[d] = 1'b1;
    tick();
    check({name, " release rdy/busy/ov"}, 128'({rdy_w[d], bsy_w[d], ov_w[d]}), 128'(3'b100));
  endtask

  localparam blk_t C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam blk_t PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  vec_t vecs [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rkey;
    blk_t         rct;
    int           d;

    vecs[0] = '{0, C1_KEY, C1_CT, PT, 11, 5, "fips_c1"};
    vecs[1] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 11, 0, "fips_b"};
    vecs[2] = '{1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, PT, 15, 1, "fips_c3"};

    build_sbox();
    for (int i = 0; i < 2; i++) begin
      start_s[i]     = 1'b0;
      in_s[i]        = '0;
      out_ready_s[i] = 1'b1;
`ifdef AES_DEC_ABORT_EN
      abort_s[i]     = 1'b0;
`endif
      for (int r = 0; r < 16; r++) ks[i][r] = '0;
    end
    reset_n = 1'b0;
    repeat (2) tick();
    check_reset(0, "por a");
    check_reset(1, "por b");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      expand_key(vecs[i].d, vecs[i].key);
      do_accept(vecs[i].d, vecs[i].ct);
      track(vecs[i].d, vecs[i].pt, vecs[i].lat, vecs[i].stall, vecs[i].name);
    end

    // Reset in the middle of round processing, then a clean rerun.
    expand_key(0, C1_KEY);
    do_accept(0, C1_CT);
    repeat (6) tick();
    #2 reset_n = 1'b0;
    #1 check_reset(0, "mid reset");
    repeat (2) begin
      tick();
      check("mid reset no out_valid", 128'(ov_w[0]), 128'd0);
    end
    reset_n = 1'b1;
    tick();
    do_accept(0, C1_CT);
    track(0, PT, 11, 0, "after reset");

`ifdef AES_DEC_ABORT_EN
    do_accept(0, C1_CT);
    repeat (3) tick();
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    check("abort rdy/busy/ov", 128'({rdy_w[0], bsy_w[0], ov_w[0]}), 128'(3'b100));
    check("abort rk_idx", 128'(rkidx_w[0]), 128'd0);
    check("abort out_block kept", ob_w[0], PT);
    abort_s[0] = 1'b1;
    do_accept(0, C1_CT);
    abort_s[0] = 1'b0;
    track(0, PT, 11, 0, "after abort");
`endif

    for (int it = 0; it < 12; it++) begin
      d    = int'($urandom_range(0, 1));
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      rct  = rand_blk();
      expand_key(d, rkey);
      do_accept(d, rct);
      track(d, model_dec(d, rct), nr_of(d) + 1, int'($urandom_range(0, 3)),
            $sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
